// File: rtl/spi_engine_cmd_sequencer.sv
// spi_engine_cmd_sequencer: expands one transfer request into the SPI Engine instruction stream,
// skipping config and DLENGTH instructions that the engine already holds.
module spi_engine_cmd_sequencer #(
  parameter int         NUM_CS             = 1,
  parameter logic [7:0] DEFAULT_PRESCALE   = 8'd0,
  parameter logic       DEFAULT_CPOL       = 1'b0,
  parameter logic       DEFAULT_CPHA       = 1'b0,
  parameter logic       DEFAULT_THREE_WIRE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cs,
  input  logic [1:0]  req_mode,
  input  logic [7:0]  req_len,
  input  logic [7:0]  req_dlength,
  input  logic [1:0]  req_cs_delay,
  input  logic [7:0]  req_sleep,
  input  logic        cfg_update,
  input  logic [7:0]  cfg_prescale,
  input  logic        cfg_cpol,
  input  logic        cfg_cpha,
  input  logic        cfg_three_wire,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_data,
  output logic        busy,
  output logic [7:0]  last_sync_id
);
  typedef enum logic [3:0] {
    S_IDLE, S_PRESCALE, S_CFG, S_DLEN, S_CS_ON, S_XFER, S_CS_OFF, S_SLEEP, S_SYNC
  } state_t;

  localparam logic [3:0] CS_N = 4'(NUM_CS);

  state_t      r_state, w_nxt;
  logic        r_cmd_valid, r_busy, r_req_ready;
  logic [15:0] r_cmd_data, w_enc;
  logic [7:0]  r_last_id, r_cnt;
  logic        r_dvalid, r_pend, r_stale;
  logic [7:0]  r_dcache;
  logic [7:0]  r_prescale;
  logic        r_cpol, r_cpha, r_3w;
  logic [2:0]  r_cs;
  logic [1:0]  r_mode, r_delay;
  logic [7:0]  r_len, r_dlen, r_sleep;

  logic        w_acc, w_hs, w_pend, w_dmiss;
  logic [2:0]  w_cs, w_idx;
  logic [1:0]  w_mode, w_delay;
  logic [7:0]  w_len, w_dlen, w_sleep, w_prescale, w_mask;
  logic        w_cpol, w_cpha, w_3w;

  // The first instruction is loaded in the accept cycle, so request and config fields are forwarded.
  assign w_acc      = req_valid & r_req_ready;
  assign w_hs       = r_cmd_valid & cmd_ready;
  assign w_cs       = w_acc ? req_cs : r_cs;
  assign w_mode     = w_acc ? req_mode : r_mode;
  assign w_len      = w_acc ? req_len : r_len;
  assign w_dlen     = w_acc ? req_dlength : r_dlen;
  assign w_delay    = w_acc ? req_cs_delay : r_delay;
  assign w_sleep    = w_acc ? req_sleep : r_sleep;
  assign w_prescale = cfg_update ? cfg_prescale : r_prescale;
  assign w_cpol     = cfg_update ? cfg_cpol : r_cpol;
  assign w_cpha     = cfg_update ? cfg_cpha : r_cpha;
  assign w_3w       = cfg_update ? cfg_three_wire : r_3w;
  assign w_pend     = r_pend | cfg_update;
  assign w_dmiss    = !r_dvalid || (r_dcache != w_dlen);
  assign w_idx      = ({1'b0, w_cs} < CS_N) ? w_cs : 3'd0;
  assign w_mask     = ~(8'd1 << w_idx);

  always_comb begin
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:     w_nxt = w_pend ? S_PRESCALE : (w_dmiss ? S_DLEN : S_CS_ON);
      S_PRESCALE: w_nxt = S_CFG;
      S_CFG:      w_nxt = w_dmiss ? S_DLEN : S_CS_ON;
      S_DLEN:     w_nxt = S_CS_ON;
      S_CS_ON:    w_nxt = (w_mode == 2'b00) ? S_CS_OFF : S_XFER;
      S_XFER:     w_nxt = S_CS_OFF;
      S_CS_OFF:   w_nxt = (w_sleep != 8'd0) ? S_SLEEP : S_SYNC;
      S_SLEEP:    w_nxt = S_SYNC;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_enc = 16'h0000;
    case (w_nxt)
      S_PRESCALE: w_enc = {8'h20, w_prescale};
      S_CFG:      w_enc = {8'h21, 5'd0, w_3w, w_cpol, w_cpha};
      S_DLEN:     w_enc = {8'h22, w_dlen};
      S_CS_ON:    w_enc = {6'b000100, w_delay, w_mask};
      S_XFER:     w_enc = {6'd0, w_mode, w_len};
      S_CS_OFF:   w_enc = {6'b000100, w_delay, 8'hFF};
      S_SLEEP:    w_enc = {8'h31, w_sleep};
      S_SYNC:     w_enc = {8'h30, r_cnt};
      default:    w_enc = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= 16'h0000;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
      r_last_id   <= 8'd0;
      r_cnt       <= 8'd0;
      r_dvalid    <= 1'b0;
      r_dcache    <= 8'd0;
      r_pend      <= 1'b1;
      r_stale     <= 1'b0;
      r_prescale  <= DEFAULT_PRESCALE;
      r_cpol      <= DEFAULT_CPOL;
      r_cpha      <= DEFAULT_CPHA;
      r_3w        <= DEFAULT_THREE_WIRE;
      r_cs        <= 3'd0;
      r_mode      <= 2'd0;
      r_len       <= 8'd0;
      r_dlen      <= 8'd0;
      r_delay     <= 2'd0;
      r_sleep     <= 8'd0;
    end else begin
      if (cfg_update) begin
        r_prescale <= cfg_prescale;
        r_cpol     <= cfg_cpol;
        r_cpha     <= cfg_cpha;
        r_3w       <= cfg_three_wire;
      end
      if (w_acc) begin
        r_cs    <= req_cs;
        r_mode  <= req_mode;
        r_len   <= req_len;
        r_dlen  <= req_dlength;
        r_delay <= req_cs_delay;
        r_sleep <= req_sleep;
      end
      // An update landing while PRESCALE/CFG is in flight must survive the CFG handshake.
      if (w_hs && r_state == S_CFG) begin
        r_pend  <= cfg_update | r_stale;
        r_stale <= 1'b0;
      end else if (cfg_update) begin
        r_pend  <= 1'b1;
        r_stale <= r_stale | (r_state == S_PRESCALE) | (r_state == S_CFG);
      end
      if (w_hs && r_state == S_DLEN) begin
        r_dvalid <= 1'b1;
        r_dcache <= r_dlen;
      end
      if (w_hs && r_state == S_SYNC) begin
        r_last_id <= r_cnt;
        r_cnt     <= r_cnt + 8'd1;
      end
      if (w_acc || w_hs) begin
        r_state     <= w_nxt;
        r_cmd_valid <= (w_nxt != S_IDLE);
        r_cmd_data  <= w_enc;
        r_busy      <= (w_nxt != S_IDLE);
        r_req_ready <= (w_nxt == S_IDLE);
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign cmd_valid    = r_cmd_valid;
  assign cmd_data     = r_cmd_data;
  assign busy         = r_busy;
  assign last_sync_id = r_last_id;
endmodule
